// File: rtl/aes_dec_round_sched.sv
// aes_dec_round_sched
// Round scheduler for the AES inverse cipher. Runs ARK / ISB / IMC over the
// shared statemt memory in decryption order, drives the ARK round index and
// selects which sub-block owns statemt.
//
// Optional build macro: SCHED_TIMEOUT_EN adds a per-op watchdog that aborts
// the run with err=1 when a sub-block never answers.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for ap_start
// S_ARK0 | initial AddRoundKey with n=NR
// S_ISB  | InvShiftRow+ByteSub of an inner round
// S_ARK  | AddRoundKey of an inner round, n=round
// S_IMC  | InvMixColumn of an inner round
// S_FISB | InvShiftRow+ByteSub of the final round
// S_FARK | final AddRoundKey with n=0
// S_END  | one-cycle ap_done/ap_ready pulse, then back to S_IDLE
module aes_dec_round_sched #(
    parameter int N_W = 5
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    input  logic           ap_start,
    input  logic [1:0]     key_type,
    output logic           ap_done,
    output logic           ap_ready,
    output logic           ap_idle,
    output logic           err,
    output logic           ark_start,
    input  logic           ark_done,
    output logic [N_W-1:0] ark_n,
    output logic           isb_start,
    input  logic           isb_done,
    output logic           imc_start,
    input  logic           imc_done,
    output logic [1:0]     mem_sel
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARK0, S_ISB, S_ARK, S_IMC, S_FISB, S_FARK, S_END
    } state_t;

    localparam logic [1:0] SEL_ARK  = 2'd0;
    localparam logic [1:0] SEL_ISB  = 2'd1;
    localparam logic [1:0] SEL_IMC  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    state_t         r_state;
    logic [N_W-1:0] r_round;
    logic [N_W-1:0] r_ark_n;
    logic           r_ark_start;
    logic           r_isb_start;
    logic           r_imc_start;
    logic [1:0]     r_mem_sel;
    logic           r_done;
    logic           r_idle;
    logic           r_err;
    logic           r_err_pend;

    logic [N_W-1:0] w_nr;
    logic           w_timeout;

    // Number of rounds for the requested key size; 0 for the illegal code
    always_comb begin
        w_nr = '0;
        case (key_type)
            2'd0:    w_nr = N_W'(10);
            2'd1:    w_nr = N_W'(12);
            2'd2:    w_nr = N_W'(14);
            default: w_nr = '0;
        endcase
    end

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       w_any_start;
    logic       w_act_done;

    assign w_any_start = r_ark_start | r_isb_start | r_imc_start;
    assign w_act_done  = (r_ark_start & ark_done) | (r_isb_start & isb_done)
                       | (r_imc_start & imc_done);
    assign w_timeout   = w_any_start && !w_act_done
                       && (r_to_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles an issued op waits; idles at 0 between ops so
    // every issue starts from a cleared count
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_any_start || w_act_done || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Scheduler FSM: each op state first issues its start (one cycle after the
    // previous done), then waits for its own done and moves on
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_round     <= '0;
            r_ark_n     <= '0;
            r_ark_start <= 1'b0;
            r_isb_start <= 1'b0;
            r_imc_start <= 1'b0;
            r_mem_sel   <= SEL_NONE;
            r_done      <= 1'b0;
            r_idle      <= 1'b1;
            r_err       <= 1'b0;
            r_err_pend  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timeout) begin
                r_ark_start <= 1'b0;
                r_isb_start <= 1'b0;
                r_imc_start <= 1'b0;
                r_mem_sel   <= SEL_NONE;
                r_err_pend  <= 1'b1;
                r_state     <= S_END;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (ap_start) begin
                            r_idle <= 1'b0;
                            if (key_type != 2'd3) begin
                                r_round     <= w_nr;
                                r_ark_n     <= w_nr;
                                r_ark_start <= 1'b1;
                                r_mem_sel   <= SEL_ARK;
                                r_err_pend  <= 1'b0;
                                r_state     <= S_ARK0;
                            end else begin
                                r_err_pend <= 1'b1;
                                r_state    <= S_END;
                            end
                        end
                    end
                    S_ARK0: begin
                        if (r_ark_start && ark_done) begin
                            r_ark_start <= 1'b0;
                            r_mem_sel   <= SEL_NONE;
                            r_round     <= r_round - N_W'(1);
                            r_state     <= S_ISB;
                        end
                    end
                    S_ISB, S_FISB: begin
                        if (!r_isb_start) begin
                            r_isb_start <= 1'b1;
                            r_mem_sel   <= SEL_ISB;
                        end else if (isb_done) begin
                            r_isb_start <= 1'b0;
                            r_mem_sel   <= SEL_NONE;
                            r_state     <= (r_state == S_ISB) ? S_ARK : S_FARK;
                        end
                    end
                    S_ARK, S_FARK: begin
                        if (!r_ark_start) begin
                            r_ark_start <= 1'b1;
                            r_mem_sel   <= SEL_ARK;
                            r_ark_n     <= (r_state == S_FARK) ? '0 : r_round;
                        end else if (ark_done) begin
                            r_ark_start <= 1'b0;
                            r_mem_sel   <= SEL_NONE;
                            r_state     <= (r_state == S_ARK) ? S_IMC : S_END;
                        end
                    end
                    S_IMC: begin
                        if (!r_imc_start) begin
                            r_imc_start <= 1'b1;
                            r_mem_sel   <= SEL_IMC;
                        end else if (imc_done) begin
                            r_imc_start <= 1'b0;
                            r_mem_sel   <= SEL_NONE;
                            // round==1 means the last inner round is done;
                            // the final round has no IMC and uses n=0
                            if (r_round > N_W'(1)) begin
                                r_round <= r_round - N_W'(1);
                                r_state <= S_ISB;
                            end else begin
                                r_state <= S_FISB;
                            end
                        end
                    end
                    S_END: begin
                        r_done  <= 1'b1;
                        r_err   <= r_err_pend;
                        r_idle  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ap_done   = r_done;
    assign ap_ready  = r_done;
    assign ap_idle   = r_idle;
    assign err       = r_err;
    assign ark_start = r_ark_start;
    assign isb_start = r_isb_start;
    assign imc_start = r_imc_start;
    assign ark_n     = r_ark_n;
    assign mem_sel   = r_mem_sel;

endmodule
